lvds_7to1_rx_align: RTL
=======================

Name: lvds_7to1_rx_align

Overview:
- Receive-side word aligner for the 7:1 LVDS link; the counterpart of the transmit path clocked by the TX PLL.
- Sits after the per-lane 1:7 deserializers in the recovered pixel-clock domain.
- Watches the deserialized clock-lane word and pulses the deserializers' bitslip input until that word equals the LVDS clock pattern.
- Declares alignment, then forwards the data lanes registered with a valid flag, and re-trains on loss of pattern or loss of PLL lock.

Parameters:
- LANES, 4, number of 7-bit data lanes.
- CLK_PATTERN, 7'b1100011, expected clock-lane word when aligned.
- SETTLE_CYCLES, 64, cycles of stable pll_lock before training starts (>=1).
- MATCH_COUNT, 16, consecutive matching words required to declare alignment (>=1).
- SLIP_WAIT, 4, idle cycles after each bitslip pulse so the deserializer can apply it (>=1).
- ERR_LIMIT, 4, consecutive mismatching words in LOCKED that force re-training (>=1).
- MAX_SLIPS, 14, slips without success before align_fail is raised (2 full rotations).

Ports:
- clkin  in  1  recovered pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  RX PLL lock; asynchronous source, double-flop synchronized internally.
- clk_word  in  7  deserialized clock-lane word, one per cycle.
- data_word  in  7*LANES  deserialized data lanes; lane 0 in bits [6:0].
- bitslip  out  1  one-cycle slip pulse to all deserializers.
- aligned  out  1  high while in LOCKED.
- align_fail  out  1  sticky: MAX_SLIPS reached without alignment.
- slip_count  out  4  slips issued in the current training attempt, saturating at 15.
- data_out  out  7*LANES  data_word registered.
- data_valid  out  1  qualifies data_out.

Behaviour:
- Reset: state=WAIT_SETTLE; all counters 0. bitslip=0, aligned=0, align_fail=0, slip_count=0, data_out=0, data_valid=0. The synchronizer flops also clear.
- lock_s is pll_lock after 2 flops, so there are 2 cycles of latency.
- WAIT_SETTLE:
  - settle_cnt increments while lock_s=1 and clears to 0 while lock_s=0.
  - When settle_cnt reaches SETTLE_CYCLES-1 with lock_s=1: go to CHECK, match_cnt=0, slip_count=0.
- CHECK:
  - clk_word==CLK_PATTERN: match_cnt++. If this is the MATCH_COUNT-th consecutive match, go to LOCKED and clear align_fail.
  - Mismatch: go to SLIP, match_cnt=0.
- SLIP:
  - bitslip=1 for exactly this one cycle; slip_count increments (saturating).
  - If the incremented count equals MAX_SLIPS, set align_fail=1 and reset slip_count to 0. Training continues after this.
  - Next state is SLIP_WAIT.
- SLIP_WAIT: stays SLIP_WAIT cycles, with clk_word ignored, then goes to CHECK with match_cnt=0.
- LOCKED:
  - aligned=1.
  - err_cnt increments on each mismatching clk_word and clears on any match.
  - At the ERR_LIMIT-th consecutive mismatch: go to CHECK, clear match_cnt and slip_count, aligned=0 from the next cycle. No bitslip is issued on that transition.
- lock_s=0 in any state other than WAIT_SETTLE: go to WAIT_SETTLE on the next edge; aligned and data_valid fall with it. This takes priority over all other transitions.
- Outputs:
  - aligned is a registered decode of state==LOCKED, high on the first cycle in LOCKED.
  - data_out <= data_word every cycle, so it has 1-cycle latency.
  - data_valid <= (next state is LOCKED), so data_valid and aligned rise and fall together.
- bitslip is registered and never high in two consecutive cycles. Minimum spacing between pulses is SLIP_WAIT+2 cycles.
- Counter widths: each is sized by $clog2 of its limit+1. No wrap is possible before its compare.
- Reset mid-slip: reset wins, so bitslip=0 on the next cycle.

Test Plan:
- Deserializer model rotates clk_word by one bit per bitslip. Case 1: rotation 0, pll_lock held high, defaults. No bitslip. aligned rises after 2 sync + 64 settle + 16 match cycles. data_out equals data_word delayed by 1 cycle.
- Initial rotation 3: exactly 3 bitslip pulses, each separated by at least 6 cycles. Then aligned=1, slip_count=3, align_fail=0.
- clk_word stuck at 7'h00: bitslip keeps pulsing. align_fail=1 after the 14th pulse, slip_count returns to 0, and training continues. Restoring a correct pattern leads to aligned=1 and align_fail=0.
- In LOCKED: 3 bad words then 1 good word leaves aligned=1. 4 consecutive bad words drop aligned and data_valid one cycle later, with no bitslip pulse.
- In LOCKED, drop pll_lock for 1 cycle: aligned=0 within 3 cycles. After lock returns, the full settle period of 64 cycles passes before CHECK resumes.
- Assert reset during the SLIP cycle: all outputs are 0 next cycle, and training restarts from WAIT_SETTLE.

Source files
------------

// File: rtl/lvds_7to1_rx_align.sv
// Receive-side 7:1 LVDS word aligner: slips the deserializers until the clock
// lane shows the LVDS clock pattern, then forwards the data lanes qualified by data_valid.
module lvds_7to1_rx_align #(
   parameter int unsigned LANES         = 4,
   parameter logic [6:0]  CLK_PATTERN   = 7'b1100011,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned MATCH_COUNT   = 16,
   parameter int unsigned SLIP_WAIT     = 4,
   parameter int unsigned ERR_LIMIT     = 4,
   parameter int unsigned MAX_SLIPS     = 14
) (
   input  logic                 clkin,
   input  logic                 reset,
   input  logic                 pll_lock,
   input  logic [6:0]           clk_word,
   input  logic [7*LANES-1:0]   data_word,
   output logic                 bitslip,
   output logic                 aligned,
   output logic                 align_fail,
   output logic [3:0]           slip_count,
   output logic [7*LANES-1:0]   data_out,
   output logic                 data_valid
);

   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
   localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT + 1);
   localparam int unsigned ERR_W    = $clog2(ERR_LIMIT + 1);

   typedef enum logic [2:0] {
      ST_WAIT_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_SLIP_WAIT,
      ST_LOCKED
   } state_t;

   state_t              state, state_n;
   logic                sync1, lock_s;
   logic [SETTLE_W-1:0] settle_cnt, settle_n;
   logic [MATCH_W-1:0]  match_cnt, match_n;
   logic [WAIT_W-1:0]   wait_cnt, wait_n;
   logic [ERR_W-1:0]    err_cnt, err_n;
   logic [3:0]          slip_n, slip_inc;
   logic                fail_n;
   logic                word_ok;

   assign word_ok  = (clk_word == CLK_PATTERN);
   assign slip_inc = (slip_count == 4'd15) ? 4'd15 : slip_count + 4'd1;

   // State register, lock synchronizer and registered outputs
   always_ff @(posedge clkin) begin
      if (reset) begin
         sync1      <= 1'b0;
         lock_s     <= 1'b0;
         state      <= ST_WAIT_SETTLE;
         settle_cnt <= '0;
         match_cnt  <= '0;
         wait_cnt   <= '0;
         err_cnt    <= '0;
         slip_count <= 4'd0;
         align_fail <= 1'b0;
         bitslip    <= 1'b0;
         aligned    <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= '0;
      end else begin
         sync1      <= pll_lock;
         lock_s     <= sync1;
         state      <= state_n;
         settle_cnt <= settle_n;
         match_cnt  <= match_n;
         wait_cnt   <= wait_n;
         err_cnt    <= err_n;
         slip_count <= slip_n;
         align_fail <= fail_n;
         bitslip    <= (state_n == ST_SLIP);
         aligned    <= (state_n == ST_LOCKED);
         data_valid <= (state_n == ST_LOCKED);
         data_out   <= data_word;
      end
   end

   // Next-state and counter updates
   always_comb begin
      state_n  = state;
      settle_n = settle_cnt;
      match_n  = match_cnt;
      wait_n   = wait_cnt;
      err_n    = err_cnt;
      slip_n   = slip_count;
      fail_n   = align_fail;

      case (state)
         ST_WAIT_SETTLE: begin
            if (!lock_s) begin
               settle_n = '0;
            end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
               state_n  = ST_CHECK;
               settle_n = '0;
               match_n  = '0;
               slip_n   = 4'd0;
            end else begin
               settle_n = settle_cnt + SETTLE_W'(1);
            end
         end
         ST_CHECK: begin
            if (word_ok) begin
               if (match_cnt == MATCH_W'(MATCH_COUNT - 1)) begin
                  state_n = ST_LOCKED;
                  match_n = '0;
                  err_n   = '0;
                  fail_n  = 1'b0;
               end else begin
                  match_n = match_cnt + MATCH_W'(1);
               end
            end else begin
               // slip_count/align_fail update as the pulse is issued
               state_n = ST_SLIP;
               match_n = '0;
               if (slip_inc == 4'(MAX_SLIPS)) begin
                  slip_n = 4'd0;
                  fail_n = 1'b1;
               end else begin
                  slip_n = slip_inc;
               end
            end
         end
         ST_SLIP: begin
            state_n = ST_SLIP_WAIT;
            wait_n  = '0;
         end
         ST_SLIP_WAIT: begin
            if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
               state_n = ST_CHECK;
               wait_n  = '0;
               match_n = '0;
            end else begin
               wait_n = wait_cnt + WAIT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (word_ok) begin
               err_n = '0;
            end else if (err_cnt == ERR_W'(ERR_LIMIT - 1)) begin
               state_n = ST_CHECK;
               err_n   = '0;
               match_n = '0;
               slip_n  = 4'd0;
            end else begin
               err_n = err_cnt + ERR_W'(1);
            end
         end
         default: begin
            state_n = ST_WAIT_SETTLE;
         end
      endcase

      // Loss of lock overrides every other transition
      if (!lock_s && (state != ST_WAIT_SETTLE)) begin
         state_n  = ST_WAIT_SETTLE;
         settle_n = '0;
         match_n  = '0;
         wait_n   = '0;
         err_n    = '0;
         slip_n   = 4'd0;
      end
   end

endmodule
